// File: rtl/blink_rate_ctrl_if.sv
// Board-side signals of the blink rate controller: buttons and hold switch in,
// square-wave output and rate status out.
interface blink_rate_ctrl_if;
   logic       btn_up;
   logic       btn_dn;
   logic       sw_hold;
   logic       out;
   logic [4:0] tap;
   logic       busy;

   modport master (
      output btn_up, btn_dn, sw_hold,
      input  out, tap, busy
   );

   modport slave (
      input  btn_up, btn_dn, sw_hold,
      output out, tap, busy
   );
endinterface

// File: rtl/blink_rate_ctrl.sv
// Prescaler-tap rate controller for the LED/test output. Button presses retarget
// the tap; the new tap is applied only at an output edge so no runt pulse appears.
//
// state | meaning
// IDLE  | tap_tgt == tap_cur, nothing scheduled
// PEND  | rate change scheduled, applied at the next unheld tick
module blink_rate_ctrl #(
   parameter int CNT_W   = 23,
   parameter int TAP_MIN = 18,
   parameter int TAP_MAX = 22,
   parameter int TAP_RST = 20,
   parameter int DEB_W   = 16
) (
   input logic             clk,
   input logic             rst,
   blink_rate_ctrl_if.slave bus
);

   localparam logic [4:0] TMIN = 5'(TAP_MIN);
   localparam logic [4:0] TMAX = 5'(TAP_MAX);
   localparam logic [4:0] TRST = 5'(TAP_RST);

   typedef enum logic {IDLE, PEND} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] mask;
   logic             out_q;
   logic             busy_q;
   logic [4:0]       tap_cur;
   logic [4:0]       tap_tgt;
   logic [4:0]       tgt_nxt;
   logic             tick;
   logic             apply;

   logic [1:0]       up_sync;
   logic [1:0]       dn_sync;
   logic [1:0]       hold_sync;
   logic             hold;
   logic [1:0]       sync_lvl;
   logic [1:0]       deb_lvl;
   logic [1:0]       deb_dly;
   logic [DEB_W-1:0] deb_cnt [2];
   logic [1:0]       press;
   logic             up_p;
   logic             dn_p;

   assign sync_lvl = {dn_sync[1], up_sync[1]};
   assign hold     = hold_sync[1];
   assign press    = deb_lvl & ~deb_dly;
   assign up_p     = press[0] & ~press[1];
   assign dn_p     = press[1] & ~press[0];

   assign mask  = (CNT_W'(1) << tap_cur) - CNT_W'(1);
   assign tick  = &(cnt | ~mask);
   assign apply = tick & ~hold;

   always_comb begin
      tgt_nxt = tap_tgt;
      if (up_p && (tap_tgt > TMIN))
         tgt_nxt = tap_tgt - 5'd1;
      else if (dn_p && (tap_tgt < TMAX))
         tgt_nxt = tap_tgt + 5'd1;
   end

   // Debounce counter only runs while the synced level disagrees with the
   // debounced one, so any bounce back restarts the stability window.
   always_ff @(posedge clk) begin
      if (rst) begin
         up_sync   <= '0;
         dn_sync   <= '0;
         hold_sync <= '0;
         deb_lvl   <= '0;
         deb_dly   <= '0;
         for (int i = 0; i < 2; i++)
            deb_cnt[i] <= '0;
      end else begin
         up_sync   <= {up_sync[0], bus.btn_up};
         dn_sync   <= {dn_sync[0], bus.btn_dn};
         hold_sync <= {hold_sync[0], bus.sw_hold};
         deb_dly   <= deb_lvl;
         for (int i = 0; i < 2; i++) begin
            if (sync_lvl[i] == deb_lvl[i]) begin
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
               if (&deb_cnt[i])
                  deb_lvl[i] <= sync_lvl[i];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         out_q   <= 1'b0;
         tap_cur <= TRST;
         tap_tgt <= TRST;
         state   <= IDLE;
         busy_q  <= 1'b0;
      end else begin
         cnt     <= cnt + CNT_W'(1);
         tap_tgt <= tgt_nxt;
         if (apply)
            out_q <= ~out_q;
         case (state)
            IDLE: begin
               if (tgt_nxt != tap_tgt) begin
                  state  <= PEND;
                  busy_q <= 1'b1;
               end
            end
            PEND: begin
               // A press landing on the apply cycle is folded in rather than stranded.
               if (apply) begin
                  tap_cur <= tgt_nxt;
                  state   <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.out  = out_q;
   assign bus.tap  = tap_cur;
   assign bus.busy = busy_q;

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// Directed scoreboard bench for blink_rate_ctrl with a small prescaler and short debounce.
module tb_blink_rate_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic [7:0] mcnt;

   blink_rate_ctrl_if bus ();

   blink_rate_ctrl #(
      .CNT_W  (8),
      .TAP_MIN(1),
      .TAP_MAX(5),
      .TAP_RST(3),
      .DEB_W  (2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Free-running cycle count since reset release; equals the prescaler value.
   always @(posedge clk) begin
      if (rst) mcnt <= 8'd0;
      else     mcnt <= mcnt + 8'd1;
   end

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   passed = 0;
   int   total  = 0;

   task automatic push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.exp = v;
      sb.push_back(e);
   endtask

   task automatic check(input logic [31:0] act);
      exp_t e;
      total++;
      if (sb.size() == 0) begin
         $error("FAIL sb_empty: observed %0d required an expectation", act);
         return;
      end
      e = sb.pop_front();
      assert (act === e.exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", e.tag, act, e.exp);
   endtask

   task automatic cyc1();
      @(posedge clk);
      #1;
   endtask

   task automatic cycles(input int n);
      repeat (n) cyc1();
   endtask

   task automatic wait_out_edge(input int budget, output int n);
      logic o;
      o = bus.out;
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         cyc1();
         if (bus.out !== o) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic wait_busy(input logic lvl, input int budget, output int n);
      n = -1;
      for (int i = 0; i <= budget; i++) begin
         if (bus.busy === lvl) begin
            n = i;
            break;
         end
         cyc1();
      end
   endtask

   task automatic press(input bit up, output bit seen);
      seen = 1'b0;
      if (up) bus.btn_up = 1'b1;
      else    bus.btn_dn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc1();
         if (bus.busy === 1'b1) seen = 1'b1;
      end
      bus.btn_up = 1'b0;
      bus.btn_dn = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cyc1();
         if (bus.busy === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycles(2);
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit seen;

      rst         = 1'b1;
      bus.btn_up  = 1'b0;
      bus.btn_dn  = 1'b0;
      bus.sw_hold = 1'b0;
      cycles(3);
      push("rst_tap", 3);  check(bus.tap);
      push("rst_busy", 0); check(bus.busy);
      push("rst_out", 0);  check(bus.out);
      rst = 1'b0;

      // 1: default rate, period 16
      push("t1_first_rise", 8); wait_out_edge(20, n); check(n);
      push("t1_out_high", 1);   check(bus.out);
      push("t1_phase", 8);      check(mcnt);
      for (int k = 0; k < 3; k++) begin
         push("t1_period", 8); wait_out_edge(20, n); check(n);
      end
      cycles(32);
      push("t1_tap", 3);  check(bus.tap);
      push("t1_busy", 0); check(bus.busy);

      // 2: one up press from cnt=20
      for (int i = 0; i < 300; i++) begin
         if (mcnt == 8'd20) break;
         cyc1();
      end
      bus.btn_up = 1'b1;
      push("t2_busy_lat", 7); wait_busy(1'b1, 8, n); check(n);
      cycles((n > 0) ? 10 - n : 2);
      bus.btn_up = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (bus.tap !== 5'd3) break;
         cyc1();
      end
      push("t2_tap", 2);     check(bus.tap);
      push("t2_busy", 0);    check(bus.busy);
      push("t2_apply_cnt", 32); check(mcnt);
      for (int k = 0; k < 2; k++) begin
         push("t2_period", 4); wait_out_edge(10, n); check(n);
      end

      // 3: saturation at TAP_MAX
      do_reset();
      press(1'b0, seen);
      push("t3_busy_seen", 1); check(seen);
      wait_busy(1'b0, 64, n);
      push("t3_tap4", 4); check(bus.tap);
      press(1'b0, seen);
      wait_busy(1'b0, 64, n);
      push("t3_tap5", 5); check(bus.tap);
      press(1'b0, seen);
      for (int i = 0; i < 32; i++) begin
         cyc1();
         if (bus.busy === 1'b1) seen = 1'b1;
      end
      push("t3_sat_busy", 0); check(seen);
      push("t3_sat_tap", 5);  check(bus.tap);

      // 4: 3-cycle glitch is filtered
      do_reset();
      bus.btn_up = 1'b1;
      cycles(3);
      bus.btn_up = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 16; i++) begin
         cyc1();
         if (bus.busy === 1'b1) seen = 1'b1;
      end
      push("t4_busy", 0); check(seen);
      push("t4_tap", 3);  check(bus.tap);

      // 5: two presses accumulate in PEND, applied in one step
      do_reset();
      bus.sw_hold = 1'b1;
      cycles(4);
      press(1'b1, seen);
      press(1'b1, seen);
      push("t5_busy", 1);       check(bus.busy);
      push("t5_tap_held", 3);   check(bus.tap);
      push("t5_out_frozen", 0); check(bus.out);
      bus.sw_hold = 1'b0;
      wait_busy(1'b0, 32, n);
      push("t5_tap", 1); check(bus.tap);
      for (int k = 0; k < 2; k++) begin
         push("t5_period", 2); wait_out_edge(6, n); check(n);
      end

      // 6: hold defers apply; reset discards a pending change
      do_reset();
      bus.sw_hold = 1'b1;
      cycles(4);
      press(1'b1, seen);
      push("t6_busy_seen", 1); check(seen);
      cycles(24);
      push("t6_out_frozen", 0); check(bus.out);
      push("t6_busy_held", 1);  check(bus.busy);
      push("t6_tap_held", 3);   check(bus.tap);
      bus.sw_hold = 1'b0;
      wait_busy(1'b0, 24, n);
      push("t6_apply_phase", 0); check(mcnt[2:0]);
      push("t6_tap", 2);         check(bus.tap);
      bus.btn_up = 1'b1;
      wait_busy(1'b1, 12, n);
      push("t6_pend", 1); check(bus.busy);
      rst = 1'b1;
      bus.btn_up = 1'b0;
      cycles(2);
      push("t6_rst_tap", 3);  check(bus.tap);
      push("t6_rst_busy", 0); check(bus.busy);
      push("t6_rst_out", 0);  check(bus.out);
      rst = 1'b0;
      cycles(2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
